// File: rtl/rv32i_lsu_if.sv
// Bus bundle for rv32i_lsu: execute-stage request, writeback response and
// the single-port view of the data RAM.
interface rv32i_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_width;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [29:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_width, req_sign, req_addr, req_wdata,
    input  rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_we, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_width, req_sign, req_addr, req_wdata,
    output rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one access at a time against a synchronous RAM.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module rv32i_lsu #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic         clk,
  input logic         reset_n,
  rv32i_lsu_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  cnt;
  logic        we_q;
  logic [1:0]  width_q;
  logic        sign_q;
  logic [1:0]  off_q;

  logic        accept;
  logic        bad_in;
  logic [1:0]  off_in;
  logic [3:0]  be_in;
  logic [31:0] sh_data;
  logic [31:0] ld_data;

  assign accept = bus.req_valid & bus.req_ready;

  // Offsets are forced to natural alignment; in trap builds misaligned
  // requests never reach the RAM, so the forced offset is then irrelevant.
  always_comb begin
    off_in = bus.req_addr[1:0];
    be_in  = '0;
    case (bus.req_width)
      2'b00: be_in = 4'b0001 << bus.req_addr[1:0];
      2'b01: begin
        off_in = {bus.req_addr[1], 1'b0};
        be_in  = 4'b0011 << {bus.req_addr[1], 1'b0};
      end
      2'b10: begin
        off_in = '0;
        be_in  = '1;
      end
      default: be_in = '0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign bad_in = (bus.req_width == 2'b11)
                | ((bus.req_width == 2'b01) & bus.req_addr[0])
                | ((bus.req_width == 2'b10) & (bus.req_addr[1:0] != 2'b00));
`else
  assign bad_in = (bus.req_width == 2'b11);
`endif

  assign sh_data = bus.mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_data = sh_data;
    case (width_q)
      2'b00:   ld_data = {{24{sign_q & sh_data[7]}},  sh_data[7:0]};
      2'b01:   ld_data = {{16{sign_q & sh_data[15]}}, sh_data[15:0]};
      default: ld_data = sh_data;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      we_q          <= 1'b0;
      width_q       <= '0;
      sign_q        <= 1'b0;
      off_q         <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q          <= bus.req_we;
            width_q       <= bus.req_width;
            sign_q        <= bus.req_sign;
            off_q         <= off_in;
            bus.req_ready <= 1'b0;
            if (bad_in) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end else begin
              state         <= ISSUE;
              bus.mem_addr  <= bus.req_addr[31:2];
              bus.mem_wdata <= bus.req_wdata << {off_in, 3'b000};
              bus.mem_be    <= be_in;
              bus.mem_we    <= bus.req_we;
            end
          end
        end
        ISSUE: begin
          bus.mem_we <= 1'b0;
          bus.mem_be <= '0;
          if (we_q) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
          end else begin
            state <= WAIT;
            cnt   <= 2'(MEM_LATENCY);
          end
        end
        WAIT: begin
          // RAM data is valid on the last of MEM_LATENCY WAIT edges.
          if (cnt <= 2'd1) begin
            cnt           <= '0;
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= ld_data;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Scoreboard bench for rv32i_lsu with a byte-lane RAM model and a shadow byte memory.
module tb_rv32i_lsu;
  localparam int unsigned LAT = 1;

  logic clk = 1'b0;
  logic reset_n;
  rv32i_lsu_if bus();

  rv32i_lsu #(.MEM_LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] ram     [64];
  logic [31:0] rd_pipe [3];

  always @(posedge clk) begin
    if (bus.mem_we)
      for (int i = 0; i < 4; i++)
        if (bus.mem_be[i]) ram[bus.mem_addr[5:0]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    rd_pipe[0] <= ram[bus.mem_addr[5:0]];
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end
  assign bus.mem_rdata = rd_pipe[LAT-1];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] shadow [256];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic logic model_bad(input logic [1:0] w, input logic [31:0] a);
    logic b;
    b = (w == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if (w == 2'b01 && a[0]) b = 1'b1;
    if (w == 2'b10 && a[1:0] != 2'b00) b = 1'b1;
`endif
    return b;
  endfunction

  function automatic int unsigned eff_addr(input logic [1:0] w, input logic [31:0] a);
    int unsigned ea;
    ea = int'(a[7:0]);
    if (w == 2'b01) ea = ea & 32'hFE;
    if (w == 2'b10) ea = ea & 32'hFC;
    return ea;
  endfunction

  function automatic int unsigned nbytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] w, input logic s, input logic [31:0] a);
    logic [31:0] v;
    int unsigned ea;
    v  = '0;
    ea = eff_addr(w, a);
    for (int unsigned i = 0; i < nbytes(w); i++) v[8*i +: 8] = shadow[(ea + i) & 255];
    if (s && w == 2'b00 && v[7])  v[31:8]  = '1;
    if (s && w == 2'b01 && v[15]) v[31:16] = '1;
    return v;
  endfunction

  task automatic model_store(input logic [1:0] w, input logic [31:0] a, input logic [31:0] wd);
    int unsigned ea;
    ea = eff_addr(w, a);
    for (int unsigned i = 0; i < nbytes(w); i++) shadow[(ea + i) & 255] = wd[8*i +: 8];
  endtask

  // Issues one request, pushes its expectation, and waits (bounded) for rsp_valid.
  task automatic do_req(input logic we, input logic [1:0] w, input logic s,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic got, output int lat, output int we_cyc, output int be_cyc,
                        output logic [3:0] be_seen, output logic [29:0] addr_seen,
                        output logic [31:0] wd_seen);
    exp_t e;
    int   k;
    e.err   = model_bad(w, a);
    e.rdata = '0;
    if (!e.err) begin
      if (we) model_store(w, a, wd);
      else    e.rdata = model_load(w, s, a);
    end
    exp_q.push_back(e);
    bus.req_we    = we;
    bus.req_width = w;
    bus.req_sign  = s;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1; we_cyc = 0; be_cyc = 0;
    be_seen = '0; addr_seen = '0; wd_seen = '0;
    while (!bus.rsp_valid && lat < 30) begin
      if (bus.mem_we) we_cyc++;
      if (bus.mem_be != 4'b0000) begin
        be_cyc++;
        be_seen   = bus.mem_be;
        addr_seen = bus.mem_addr;
        wd_seen   = bus.mem_wdata;
      end
      @(posedge clk); #1;
      lat++;
    end
    got = bus.rsp_valid;
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  logic        got;
  int          lat, we_cyc, be_cyc;
  logic [3:0]  be_seen;
  logic [29:0] addr_seen;
  logic [31:0] wd_seen;
  exp_t        e;

  task automatic test_reset();
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
    n_checks++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata); end
    n_checks++; if (bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0) begin n_fail++; $display("FAIL reset_mem_we_be: got %b/%b want 0/0000", bus.mem_we, bus.mem_be); end
    n_checks++; if (bus.mem_addr !== 30'h0 || bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr_wdata: got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata); end
  endtask

  task automatic test_store_byte();
    do_req(1'b1, 2'b00, 1'b0, 32'h50, 32'h80, got, lat, we_cyc, be_cyc, be_seen, addr_seen, wd_seen);
    n_checks++; if (!got || lat !== 2) begin n_fail++; $display("FAIL sb_latency: got valid=%b lat=%0d want 1/2", got, lat); end
    n_checks++; if (addr_seen !== 30'h14) begin n_fail++; $display("FAIL sb_mem_addr: got %h want 14", addr_seen); end
    n_checks++; if (be_seen !== 4'b0001) begin n_fail++; $display("FAIL sb_mem_be: got %b want 0001", be_seen); end
    n_checks++; if (wd_seen !== 32'h00000080) begin n_fail++; $display("FAIL sb_mem_wdata: got %h want 00000080", wd_seen); end
    n_checks++; if (we_cyc !== 1 || be_cyc !== 1) begin n_fail++; $display("FAIL sb_we_cycles: got we=%0d be=%0d want 1/1", we_cyc, be_cyc); end
    e = exp_q.pop_front();
    n_checks++; if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin n_fail++; $display("FAIL sb_rsp: got %h/%b want %h/%b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); end
    finish_rsp();
    do_req(1'b1, 2'b00, 1'b0, 32'h53, 32'h50, got, lat, we_cyc, be_cyc, be_seen, addr_seen, wd_seen);
    n_checks++; if (be_seen !== 4'b1000 || wd_seen !== 32'h50000000) begin n_fail++; $display("FAIL sb_hi_lane: got %b/%h want 1000/50000000", be_seen, wd_seen); end
    e = exp_q.pop_front();
    n_checks++; if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin n_fail++; $display("FAIL sb_hi_rsp: got %h/%b want %h/%b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); end
    finish_rsp();
  endtask

  task automatic test_store_word();
    do_req(1'b1, 2'b10, 1'b0, 32'h60, 32'h12345678, got, lat, we_cyc, be_cyc, be_seen, addr_seen, wd_seen);
    n_checks++; if (!got || lat !== 2) begin n_fail++; $display("FAIL sw_latency: got valid=%b lat=%0d want 1/2", got, lat); end
    n_checks++; if (addr_seen !== 30'h18 || be_seen !== 4'b1111 || wd_seen !== 32'h12345678) begin n_fail++; $display("FAIL sw_mem: got %h/%b/%h want 18/1111/12345678", addr_seen, be_seen, wd_seen); end
    e = exp_q.pop_front();
    n_checks++; if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin n_fail++; $display("FAIL sw_rsp: got %h/%b want %h/%b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); end
    finish_rsp();
  endtask

  task automatic test_misalign();
    do_req(1'b0, 2'b10, 1'b0, 32'h61, 32'h0, got, lat, we_cyc, be_cyc, be_seen, addr_seen, wd_seen);
`ifdef LSU_MISALIGN_TRAP_EN
    n_checks++; if (be_cyc !== 0 || we_cyc !== 0 || bus.rsp_err !== 1'b1) begin n_fail++; $display("FAIL mis_trap: got be_cyc=%0d we_cyc=%0d err=%b want 0/0/1", be_cyc, we_cyc, bus.rsp_err); end
`else
    n_checks++; if (addr_seen !== 30'h18 || be_seen !== 4'b1111 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL mis_align: got %h/%b err=%b want 18/1111/0", addr_seen, be_seen, bus.rsp_err); end
`endif
    e = exp_q.pop_front();
    n_checks++; if (!got || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin n_fail++; $display("FAIL mis_word_rsp: got %h/%b want %h/%b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); end
    finish_rsp();
    do_req(1'b1, 2'b01, 1'b0, 32'h73, 32'h0000ABCD, got, lat, we_cyc, be_cyc, be_seen, addr_seen, wd_seen);
`ifndef LSU_MISALIGN_TRAP_EN
    n_checks++; if (be_seen !== 4'b1100 || wd_seen !== 32'hABCD0000) begin n_fail++; $display("FAIL mis_half_lane: got %b/%h want 1100/abcd0000", be_seen, wd_seen); end
`endif
    e = exp_q.pop_front();
    n_checks++; if (!got || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin n_fail++; $display("FAIL mis_half_rsp: got %h/%b want %h/%b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); end
    finish_rsp();
  endtask

  task automatic test_illegal();
    do_req(1'b1, 2'b11, 1'b0, 32'h70, 32'hFFFFFFFF, got, lat, we_cyc, be_cyc, be_seen, addr_seen, wd_seen);
    n_checks++; if (we_cyc !== 0 || be_cyc !== 0) begin n_fail++; $display("FAIL illegal_no_access: got we=%0d be=%0d want 0/0", we_cyc, be_cyc); end
    e = exp_q.pop_front();
    n_checks++; if (!got || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin n_fail++; $display("FAIL illegal_rsp: got %h/%b want %h/%b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); end
    finish_rsp();
  endtask

  task automatic test_load_backpressure();
    logic [31:0] snap_d;
    logic        snap_e;
    do_req(1'b1, 2'b10, 1'b0, 32'h60, 32'hFFFB1234, got, lat, we_cyc, be_cyc, be_seen, addr_seen, wd_seen);
    e = exp_q.pop_front();
    finish_rsp();
    do_req(1'b0, 2'b01, 1'b1, 32'h62, 32'h0, got, lat, we_cyc, be_cyc, be_seen, addr_seen, wd_seen);
    n_checks++; if (!got || lat !== 2 + int'(LAT)) begin n_fail++; $display("FAIL lh_latency: got valid=%b lat=%0d want 1/%0d", got, lat, 2 + LAT); end
    n_checks++; if (bus.rsp_rdata !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL lh_signed: got %h want fffffffb", bus.rsp_rdata); end
    e = exp_q.pop_front();
    n_checks++; if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin n_fail++; $display("FAIL lh_rsp: got %h/%b want %h/%b", bus.rsp_rdata, bus.rsp_err, e.rdata, e.err); end
    snap_d = e.rdata;
    snap_e = e.err;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== snap_d || bus.rsp_err !== snap_e || bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got v=%b d=%h e=%b rdy=%b want 1/%h/%b/0", i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready, snap_d, snap_e);
      end
    end
    finish_rsp();
    do_req(1'b0, 2'b01, 1'b0, 32'h62, 32'h0, got, lat, we_cyc, be_cyc, be_seen, addr_seen, wd_seen);
    n_checks++; if (!got || bus.rsp_rdata !== 32'h0000FFFB) begin n_fail++; $display("FAIL lhu_zero_ext: got %h want 0000fffb", bus.rsp_rdata); end
    e = exp_q.pop_front();
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.req_we = 1'b0; bus.req_width = 2'b10; bus.req_sign = 1'b0;
    bus.req_addr = 32'h60; bus.req_wdata = '0; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wait_async: got rdy=%b v=%b want 1/0", bus.req_ready, bus.rsp_valid); end
    #1 reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen++;
    end
    n_checks++; if (seen !== 0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wait_no_rsp: got rsp cycles=%0d rdy=%b want 0/1", seen, bus.req_ready); end
    bus.req_we = 1'b1; bus.req_width = 2'b10; bus.req_addr = 32'hF0;
    bus.req_wdata = 32'hDEADBEEF; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0) begin n_fail++; $display("FAIL rst_issue_we: got we=%b be=%b want 0/0000", bus.mem_we, bus.mem_be); end
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [1:0]  w;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin
      do_req(1'b1, 2'b10, 1'b0, 32'h80 + 32'(4*i), $urandom, got, lat, we_cyc, be_cyc, be_seen, addr_seen, wd_seen);
      e = exp_q.pop_front();
      finish_rsp();
    end
    for (int i = 0; i < 40; i++) begin
      w = 2'($urandom_range(0, 3));
      a = 32'h80 + 32'($urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), a, $urandom,
             got, lat, we_cyc, be_cyc, be_seen, addr_seen, wd_seen);
      e = exp_q.pop_front();
      n_checks++;
      if (!got || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
        n_fail++;
        $display("FAIL b2b_rsp[%0d] w=%b a=%h: got v=%b %h/%b want %h/%b", i, w, a, got, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
      end
      // A request waiting during the response handshake must not be taken that cycle.
      bus.req_we = 1'b0; bus.req_width = 2'b00; bus.req_addr = 32'h80; bus.req_valid = 1'b1;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b0;
      n_checks++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_no_accept[%0d]: got rdy=%b v=%b want 1/0", i, bus.req_ready, bus.rsp_valid);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_width = '0;
    bus.req_sign  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    #12;
    test_reset();
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_store_byte();
    test_store_word();
    test_misalign();
    test_illegal();
    test_load_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
